// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared LFSR step function and serialiser state type
package lfsr_pkg;

    localparam int LFSR_MAX_W = 64;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    // Galois step on a right-aligned value of 'width' bits; bits above width come back as zero.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] state,
        input logic [LFSR_MAX_W-1:0] taps,
        input int                    width,
        input logic                  zero_fill
    );
        logic [LFSR_MAX_W-1:0] low_mask;
        logic [LFSR_MAX_W-1:0] width_mask;
        logic                  fb;
        low_mask   = (LFSR_MAX_W'(1) << (width - 1)) - LFSR_MAX_W'(1);
        width_mask = (low_mask << 1) | LFSR_MAX_W'(1);
        fb         = (|(state & (LFSR_MAX_W'(1) << (width - 1))))
                   ^ (zero_fill & ((state & low_mask) == '0));
        lfsr_next  = (((state << 1) ^ (taps & {LFSR_MAX_W{fb}})) & width_mask & ~LFSR_MAX_W'(1))
                   | LFSR_MAX_W'(fb);
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - LFSR register with load/step control
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] TAPS       = WIDTH'(8'b10101010),
    parameter bit               ZERO_FILL  = 1'b1,
    parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(1)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Load,
    input  logic [WIDTH-1:0] Seed,
    input  logic             Enable,
    output logic [WIDTH-1:0] State
);

    logic [LFSR_MAX_W-1:0] nxt_full;
    logic                  unused_nxt;

    assign nxt_full   = lfsr_next(LFSR_MAX_W'(State), LFSR_MAX_W'(TAPS), WIDTH, ZERO_FILL);
    assign unused_nxt = ^nxt_full;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            State <= RESET_SEED;
        end else if (Load) begin
            State <= Seed;
        end else if (Enable) begin
            State <= nxt_full[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/lfsr_serial_gen.sv
// rtl/lfsr_serial_gen.sv - LFSR pattern generator with snapshot serial read-out
module lfsr_serial_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] TAPS       = WIDTH'(8'b10101010),
    parameter bit               ZERO_FILL  = 1'b1,
    parameter bit               LSB_FIRST  = 1'b1,
    parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(1)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Load,
    input  logic [WIDTH-1:0] Seed,
    input  logic             Enable,
    input  logic             OUT_Enable,
    output logic [WIDTH-1:0] State,
    output logic             OUT,
    output logic             Valid,
    output logic             Busy,
    output logic             Done,
    output logic             Lock
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    ser_state_e       fsm;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             out_q;
    logic             done_q;

    lfsr_core #(
        .WIDTH      (WIDTH),
        .TAPS       (TAPS),
        .ZERO_FILL  (ZERO_FILL),
        .RESET_SEED (RESET_SEED)
    ) u_core (
        .Clock  (Clock),
        .Reset  (Reset),
        .Load   (Load),
        .Seed   (Seed),
        .Enable (Enable),
        .State  (State)
    );

    // sreg holds the bits still to be sent, pre-shifted so the next one is always at the exit end;
    // cnt is the index of the bit currently on OUT.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            fsm    <= IDLE;
            sreg   <= '0;
            cnt    <= '0;
            out_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    done_q <= 1'b0;
                    if (OUT_Enable) begin
                        fsm <= SHIFT;
                        cnt <= '0;
                        if (LSB_FIRST) begin
                            out_q <= State[0];
                            sreg  <= State >> 1;
                        end else begin
                            out_q <= State[WIDTH-1];
                            sreg  <= State << 1;
                        end
                    end
                end
                SHIFT: begin
                    if (cnt == LAST) begin
                        fsm    <= IDLE;
                        done_q <= 1'b0;
                    end else begin
                        cnt    <= cnt + CW'(1);
                        done_q <= ((cnt + CW'(1)) == LAST);
                        if (LSB_FIRST) begin
                            out_q <= sreg[0];
                            sreg  <= sreg >> 1;
                        end else begin
                            out_q <= sreg[WIDTH-1];
                            sreg  <= sreg << 1;
                        end
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    assign OUT   = out_q;
    assign Valid = (fsm == SHIFT);
    assign Busy  = (fsm == SHIFT);
    assign Done  = done_q;
    assign Lock  = !ZERO_FILL && (State == '0);

endmodule

// File: tb/tb_lfsr_serial_gen.sv
// tb/tb_lfsr_serial_gen.sv - self-checking bench for lfsr_serial_gen
module tb_lfsr_serial_gen;

    logic Clock = 1'b0;
    logic Reset;

    logic       ld8, en8, oe8;
    logic [7:0] sd8, st8, st8m;
    logic       out8, val8, busy8, done8, lock8;
    logic       out8m, val8m, busy8m, done8m, lock8m;

    logic       ld4z, en4z, oe4z;
    logic [3:0] sd4z, st4z;
    logic       out4z, val4z, busy4z, done4z, lock4z;

    logic       ld4n, en4n, oe4n;
    logic [3:0] sd4n, st4n;
    logic       out4n, val4n, busy4n, done4n, lock4n;

    int n_vec = 0;
    int n_err = 0;

    always #5 Clock = ~Clock;

    lfsr_serial_gen u8 (
        .Clock(Clock), .Reset(Reset), .Load(ld8), .Seed(sd8), .Enable(en8), .OUT_Enable(oe8),
        .State(st8), .OUT(out8), .Valid(val8), .Busy(busy8), .Done(done8), .Lock(lock8)
    );

    lfsr_serial_gen #(.LSB_FIRST(1'b0)) u8m (
        .Clock(Clock), .Reset(Reset), .Load(ld8), .Seed(sd8), .Enable(en8), .OUT_Enable(oe8),
        .State(st8m), .OUT(out8m), .Valid(val8m), .Busy(busy8m), .Done(done8m), .Lock(lock8m)
    );

    lfsr_serial_gen #(.WIDTH(4), .TAPS(4'b0010), .ZERO_FILL(1'b1), .RESET_SEED(4'h1)) u4z (
        .Clock(Clock), .Reset(Reset), .Load(ld4z), .Seed(sd4z), .Enable(en4z), .OUT_Enable(oe4z),
        .State(st4z), .OUT(out4z), .Valid(val4z), .Busy(busy4z), .Done(done4z), .Lock(lock4z)
    );

    lfsr_serial_gen #(.WIDTH(4), .TAPS(4'b0010), .ZERO_FILL(1'b0), .RESET_SEED(4'h1)) u4n (
        .Clock(Clock), .Reset(Reset), .Load(ld4n), .Seed(sd4n), .Enable(en4n), .OUT_Enable(oe4n),
        .State(st4n), .OUT(out4n), .Valid(val4n), .Busy(busy4n), .Done(done4n), .Lock(lock4n)
    );

    // Reference step from the arithmetic definition of a Galois LFSR.
    function automatic logic [31:0] ref_step(input logic [31:0] s, input int w,
                                             input logic [31:0] taps, input bit zf);
        int unsigned half, modv, fb, nx;
        half = 1 << (w - 1);
        modv = 1 << w;
        fb   = (s / half) % 2;
        if (zf && (s % half) == 0) fb = fb ^ 1;
        nx = (s * 2) % modv;
        if (fb != 0) nx = nx ^ ((taps & 32'hFFFF_FFFE) | 32'h1);
        return nx;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [7:0] m8;
    bit         q8[$];
    bit         qm[$];
    bit         m_last;
    bit         last_b, last_bm;
    logic [7:0] obs_frame, obs_frame_m;
    int         obs_idx;

    task automatic step(input logic ld, input logic [7:0] sd, input logic en, input logic oe);
        logic [7:0] snap;
        bit b, bm;
        ld8 = ld; sd8 = sd; en8 = en; oe8 = oe;
        snap = m8;
        if (q8.size() == 0 && !m_last && oe) begin
            for (int i = 0; i < 8; i++) begin
                q8.push_back(snap[i]);
                qm.push_back(snap[7-i]);
            end
            obs_idx = 0;
        end
        if (ld) m8 = sd;
        else if (en) m8 = 8'(ref_step(32'(m8), 8, 32'h0000_00AA, 1'b1));
        @(posedge Clock); #1;
        chk("state8", st8, m8);
        chk("state8m", st8m, m8);
        chk("lock8", lock8, 0);
        if (q8.size() > 0) begin
            b  = q8.pop_front();
            bm = qm.pop_front();
            chk("valid8", val8, 1);
            chk("busy8", busy8, 1);
            chk("out8", out8, b);
            chk("out8m", out8m, bm);
            chk("done8", done8, q8.size() == 0);
            chk("done8m", done8m, q8.size() == 0);
            obs_frame[obs_idx]       = out8;
            obs_frame_m[7 - obs_idx] = out8m;
            obs_idx++;
            last_b  = b;
            last_bm = bm;
            m_last  = (q8.size() == 0);
        end else begin
            chk("idle_valid8", val8, 0);
            chk("idle_busy8", busy8, 0);
            chk("idle_done8", done8, 0);
            chk("idle_out8", out8, last_b);
            chk("idle_out8m", out8m, last_bm);
            m_last = 0;
        end
    endtask

    initial begin
        logic [31:0] prev, exp4;
        logic [15:0] seen;

        Reset = 1'b0;
        ld8 = 0; en8 = 0; oe8 = 0; sd8 = '0;
        ld4z = 0; en4z = 0; oe4z = 0; sd4z = '0;
        ld4n = 0; en4n = 0; oe4n = 0; sd4n = '0;
        m8 = 8'h01; m_last = 0; last_b = 0; last_bm = 0; obs_idx = 0;
        obs_frame = '0; obs_frame_m = '0;
        repeat (2) @(posedge Clock);
        @(negedge Clock) Reset = 1'b1;
        @(posedge Clock); #1;

        chk("rst_state8", st8, 8'h01);
        chk("rst_out8", out8, 0);
        chk("rst_valid8", val8, 0);
        chk("rst_busy8", busy8, 0);
        chk("rst_done8", done8, 0);
        chk("rst_lock4n", lock4n, 0);
        chk("rst_state4z", st4z, 4'h1);

        // Full 16-state cycle with zero fill
        en4z = 1; prev = 1; seen = 16'h0;
        for (int i = 0; i < 16; i++) begin
            @(posedge Clock); #1;
            exp4 = ref_step(prev, 4, 32'h2, 1'b1);
            chk("t1_state", st4z, exp4);
            if (prev == 8) chk("t1_8to0", st4z, 0);
            if (prev == 0) chk("t1_0to3", st4z, 3);
            seen[st4z] = 1'b1;
            prev = exp4;
        end
        en4z = 0;
        chk("t1_visited", $countones(seen), 16);
        chk("t1_period", st4z, 1);
        chk("t1_valid_idle", val4z, 0);

        // Plain LFSR: all-zero lock-up, then period 15
        ld4n = 1; sd4n = 4'h0; en4n = 1;
        @(posedge Clock); #1;
        ld4n = 0;
        chk("t2_zero", st4n, 0);
        chk("t2_lock", lock4n, 1);
        repeat (4) begin
            @(posedge Clock); #1;
            chk("t2_stuck", st4n, 0);
            chk("t2_lock_hold", lock4n, 1);
        end
        ld4n = 1; sd4n = 4'h1;
        @(posedge Clock); #1;
        ld4n = 0; prev = 1;
        for (int i = 0; i < 15; i++) begin
            @(posedge Clock); #1;
            exp4 = ref_step(prev, 4, 32'h2, 1'b0);
            chk("t2_state", st4n, exp4);
            chk("t2_nolock", lock4n, 0);
            chk("t2_return", st4n == 4'h1, i == 14);
            prev = exp4;
        end
        en4n = 0;
        chk("t2_valid_idle", val4n, 0);

        // A5 frame, no LFSR activity
        step(1, 8'hA5, 0, 0);
        step(0, 8'h00, 0, 1);
        repeat (7) step(0, 8'h00, 0, 0);
        chk("t3_frame", obs_frame, 8'hA5);
        chk("t3_frame_msb", obs_frame_m, 8'hA5);
        step(0, 8'h00, 0, 0);
        chk("t3_busy_end", busy8, 0);

        // A5 frame while stepping, with a mid-frame load
        step(1, 8'hA5, 0, 0);
        step(0, 8'h00, 1, 1);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 1, 0);
        step(1, 8'h3C, 1, 0);
        chk("t4_load", st8, 8'h3C);
        repeat (5) step(0, 8'h00, 1, 0);
        chk("t4_frame", obs_frame, 8'hA5);
        step(0, 8'h00, 0, 0);

        // OUT_Enable held high
        for (int i = 0; i < 30; i++) step(0, 8'h00, 1'($urandom % 2), 1);
        step(0, 8'h00, 0, 0);
        while (q8.size() > 0 || m_last) step(0, 8'h00, 0, 0);

        // Reset in the middle of a frame
        step(1, 8'h5A, 0, 0);
        step(0, 8'h00, 0, 1);
        repeat (3) step(0, 8'h00, 0, 0);
        ld8 = 0; en8 = 0; oe8 = 0;
        #2 Reset = 1'b0;
        #1;
        chk("t6_valid", val8, 0);
        chk("t6_busy", busy8, 0);
        chk("t6_out", out8, 0);
        chk("t6_done", done8, 0);
        @(posedge Clock);
        @(negedge Clock) Reset = 1'b1;
        @(posedge Clock); #1;
        chk("t6_state", st8, 8'h01);
        chk("t6_valid_after", val8, 0);
        chk("t6_done_after", done8, 0);
        m8 = 8'h01; q8.delete(); qm.delete(); m_last = 0; last_b = 0; last_bm = 0;

        // Random traffic against the reference model
        for (int i = 0; i < 400; i++)
            step(1'($urandom % 8 == 0), 8'($urandom), 1'($urandom % 2), 1'($urandom % 4 == 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
